// File: rtl/decode_pkg.sv
// Shared types, opcode constants and immediate generation for the ID stage.
package decode_pkg;

  localparam int unsigned CTRL_W  = 14;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // ALU operation class handed to EX
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_BR  = 2'd1;
  localparam logic [1:0] ALU_OP  = 2'd2;
  localparam logic [1:0] ALU_OPI = 2'd3;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       is_jalr;
    logic       is_lui;
    logic       is_auipc;
    logic       is_system;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
  } decode_ctrl_t;

  // Sign-extended 32-bit immediate for the given format
  function automatic logic [31:0] gen_imm(input logic [INSTR_W-1:0] instr, input imm_sel_e sel);
    logic [31:0] imm;
    case (sel)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Generic valid/ready register slice: 2-entry (main+skid) or single-entry passthrough.
module decode_skid_buf #(
  parameter int unsigned WIDTH   = 8,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             main_valid;
  logic [WIDTH-1:0] main_data;

  assign out_valid = main_valid;
  assign out_data  = main_data;

  generate
    if (SKID_EN) begin : g_skid
      logic             skid_valid;
      logic [WIDTH-1:0] skid_data;
      logic             accept;

      // in_ready comes straight from the skid flop, breaking the ready path
      assign in_ready = ~skid_valid;
      assign accept   = in_valid & ~skid_valid & ~flush;

      // Main/skid update: refill main from skid first so order is preserved
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_data  <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end else if (~main_valid | out_ready) begin
          if (skid_valid) begin
            main_valid <= 1'b1;
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end else begin
            main_valid <= accept;
            if (accept) main_data <= in_data;
          end
        end else if (accept) begin
          skid_valid <= 1'b1;
          skid_data  <= in_data;
        end
      end
    end else begin : g_single
      logic accept;

      assign in_ready = ~main_valid | out_ready;
      assign accept   = in_valid & in_ready & ~flush;

      // Single register: load whenever the downstream slot frees up
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          main_valid <= 1'b0;
          main_data  <= '0;
        end else if (flush) begin
          main_valid <= 1'b0;
        end else if (in_ready) begin
          main_valid <= accept;
          if (accept) main_data <= in_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: combinational decode into a registered valid/ready slice, plus perf counters.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned PC_WIDTH   = 32,
  parameter bit          SKID_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [INSTR_W-1:0]    in_instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [REG_W-1:0]      out_rd,
  output logic [REG_W-1:0]      out_rs1,
  output logic [REG_W-1:0]      out_rs2,
  output logic [DATA_WIDTH-1:0] out_imm,
  output decode_ctrl_t          out_ctrl,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  dec_cnt,
  output logic [CNT_WIDTH-1:0]  ill_cnt
);

  localparam int unsigned PAY_W = PC_WIDTH + 3 * REG_W + DATA_WIDTH + CTRL_W + 1;

  decode_ctrl_t          ctrl_c;
  imm_sel_e              imm_sel_c;
  logic                  illegal_c;
  logic [DATA_WIDTH-1:0] imm_c;
  logic [PAY_W-1:0]      pay_c;
  logic [PAY_W-1:0]      pay_q;
  logic                  emit;

  // Opcode decode into control bundle and immediate format
  always_comb begin
    ctrl_c    = '0;
    imm_sel_c = IMM_NONE;
    illegal_c = 1'b0;
    case (in_instr[6:0])
      OPC_LUI: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.is_lui    = 1'b1;
        imm_sel_c        = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.is_auipc  = 1'b1;
        imm_sel_c        = IMM_U;
      end
      OPC_JAL: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.jump      = 1'b1;
        ctrl_c.wb_sel    = WB_PC4;
        imm_sel_c        = IMM_J;
      end
      OPC_JALR: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.jump      = 1'b1;
        ctrl_c.is_jalr   = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.wb_sel    = WB_PC4;
        imm_sel_c        = IMM_I;
      end
      OPC_BRANCH: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.alu_op = ALU_BR;
        imm_sel_c     = IMM_B;
      end
      OPC_LOAD: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.wb_sel    = WB_MEM;
        imm_sel_c        = IMM_I;
      end
      OPC_STORE: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        imm_sel_c        = IMM_S;
      end
      OPC_OP_IMM: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.alu_op    = ALU_OPI;
        imm_sel_c        = IMM_I;
      end
      OPC_OP: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.alu_op    = ALU_OP;
      end
      OPC_SYSTEM: begin
        ctrl_c.is_system = 1'b1;
        imm_sel_c        = IMM_I;
      end
      default: illegal_c = 1'b1;
    endcase
    // Compressed/reserved encodings never match a 32-bit opcode; kill everything
    if (in_instr[1:0] != 2'b11) begin
      illegal_c = 1'b1;
      ctrl_c    = '0;
      imm_sel_c = IMM_NONE;
    end
  end

  assign imm_c = DATA_WIDTH'($signed(gen_imm(in_instr, imm_sel_c)));
  assign pay_c = {in_pc, in_instr[11:7], in_instr[19:15], in_instr[24:20], imm_c, ctrl_c, illegal_c};

  decode_skid_buf #(
    .WIDTH   (PAY_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pay_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pay_q)
  );

  assign {out_pc, out_rd, out_rs1, out_rs2, out_imm, out_ctrl, out_illegal} = pay_q;

  // A flushed instruction never counts as handed over
  assign emit = out_valid & out_ready & ~flush;

  // Saturating perf counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      ill_cnt <= '0;
    end else if (emit) begin
      if (dec_cnt != '1) dec_cnt <= dec_cnt + CNT_WIDTH'(1);
      if (out_illegal && (ill_cnt != '1)) ill_cnt <= ill_cnt + CNT_WIDTH'(1);
    end
  end

endmodule
